// File: rtl/fft_sequencer.sv
// fft_sequencer: address and handshake sequencer for an in-place radix-2 DIT FFT
// over ping-pong RAM banks; the RAM, twiddle ROM and butterfly unit are external.
module fft_sequencer #(
    parameter int M        = 9,
    parameter int RD_LAT   = 1,
    parameter int BFLY_LAT = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic                       inverse_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic                       load_we_o,
    output logic [M-1:0]               load_adr_o,
    output logic [M-1:0]               rd_adr_a_o,
    output logic [M-1:0]               rd_adr_b_o,
    output logic                       rd_bank_o,
    output logic [M-2:0]               twiddle_adr_o,
    output logic                       twiddle_conj_o,
    output logic                       wr_en_o,
    output logic [M-1:0]               wr_adr_a_o,
    output logic [M-1:0]               wr_adr_b_o,
    output logic                       wr_bank_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [M-1:0]               out_adr_o,
    output logic [$clog2(M+1)-1:0]     level_o,
    output logic                       busy_o,
    output logic                       done_o
);
    localparam int PIPE = RD_LAT + BFLY_LAT;
    localparam int LW   = $clog2(M + 1);
    localparam int IW   = M - 1;
    localparam int DW   = $clog2(PIPE + 1);
    localparam int TW   = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, UNLOAD} state_t;

    state_t          state_q, state_d;
    logic [M-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [LW-1:0]   level_q, level_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [TW-1:0]   lat_q, lat_d;
    logic [M-1:0]    oadr_q, oadr_d;
    logic            inv_q, inv_d;
    logic            compute, drain, unload, out_hs;
    logic [M-1:0]    rev, ix, span, pos, base;
    logic [PIPE-1:0]         pv_q;
    logic [PIPE-1:0][M-1:0]  pa_q, pb_q;

    assign compute = state_q == COMPUTE;
    assign drain   = state_q == DRAIN;
    assign unload  = state_q == UNLOAD;
    assign out_hs  = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            level_q <= '0;
            dcnt_q  <= '0;
            lat_q   <= '0;
            oadr_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
            lat_q   <= lat_d;
            oadr_q  <= oadr_d;
            inv_q   <= inv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        level_d = level_q;
        dcnt_d  = dcnt_q;
        lat_d   = lat_q;
        oadr_d  = oadr_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = LOAD;
                inv_d   = inverse_i;
                cnt_d   = '0;
            end
            LOAD: if (in_valid_i) begin
                cnt_d = cnt_q + M'(1);
                if (&cnt_q) begin
                    state_d = COMPUTE;
                    idx_d   = '0;
                    level_d = '0;
                end
            end
            COMPUTE: begin
                idx_d = idx_q + IW'(1);
                if (&idx_q) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end
            end
            DRAIN: begin
                dcnt_d = dcnt_q + DW'(1);
                if (dcnt_q == DW'(PIPE - 1)) begin
                    level_d = level_q + LW'(1);
                    state_d = (level_q == LW'(M - 1)) ? UNLOAD : COMPUTE;
                    idx_d   = '0;
                    oadr_d  = '0;
                    lat_d   = '0;
                end
            end
            UNLOAD: begin
                if (out_hs) begin
                    oadr_d = oadr_q + M'(1);
                    lat_d  = '0;
                    if (&oadr_q) begin
                        state_d = IDLE;
                        level_d = '0;
                    end
                end else if (lat_q != TW'(RD_LAT)) begin
                    lat_d = lat_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rev = '0;
        for (int k = 0; k < M; k++) rev[k] = cnt_q[M-1-k];
        ix   = {1'b0, idx_q};
        span = M'(1) << level_q;
        pos  = ix & (span - M'(1));
        base = ((ix >> level_q) << (level_q + LW'(1))) | pos;
        in_ready_o     = state_q == LOAD;
        load_we_o      = in_ready_o & in_valid_i;
        load_adr_o     = in_ready_o ? rev : '0;
        rd_adr_a_o     = compute ? base : '0;
        rd_adr_b_o     = compute ? (base | span) : '0;
        twiddle_adr_o  = compute ? IW'(pos << (LW'(M - 1) - level_q)) : '0;
        twiddle_conj_o = compute & inv_q;
        rd_bank_o      = (compute | drain | unload) & level_q[0];
        wr_bank_o      = (compute | drain) & ~level_q[0];
        wr_en_o        = pv_q[PIPE-1];
        wr_adr_a_o     = pa_q[PIPE-1];
        wr_adr_b_o     = pb_q[PIPE-1];
        out_valid_o    = unload & (lat_q == TW'(RD_LAT));
        out_adr_o      = oadr_q;
        done_o         = out_valid_o & out_ready_i & (&oadr_q);
        level_o        = level_q;
        busy_o         = state_q != IDLE;
    end

    // Read issue is delayed PIPE cycles to become the matching result write.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pv_q <= '0;
            pa_q <= '0;
            pb_q <= '0;
        end else begin
            for (int k = PIPE - 1; k > 0; k--) begin
                pv_q[k] <= pv_q[k-1];
                pa_q[k] <= pa_q[k-1];
                pb_q[k] <= pb_q[k-1];
            end
            pv_q[0] <= compute;
            pa_q[0] <= rd_adr_a_o;
            pb_q[0] <= rd_adr_b_o;
        end
    end
endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: directed bench for fft_sequencer at M=3, RD_LAT=1, BFLY_LAT=2.
module tb_fft_sequencer;
    logic       clk = 1'b0;
    logic       reset, start, inverse, in_valid, out_ready;
    logic       in_ready, load_we, rd_bank, twiddle_conj, wr_en, wr_bank;
    logic       out_valid, busy, done;
    logic [2:0] load_adr, rd_adr_a, rd_adr_b, wr_adr_a, wr_adr_b, out_adr;
    logic [1:0] twiddle_adr, level;
    int tests = 0;
    int fails = 0;
    int la_tab [8]    = '{0, 4, 2, 6, 1, 5, 3, 7};
    int ra_tab [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    int rb_tab [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    int tw_tab [3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

    fft_sequencer #(.M(3), .RD_LAT(1), .BFLY_LAT(2)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .inverse_i(inverse),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .load_we_o(load_we),
        .load_adr_o(load_adr), .rd_adr_a_o(rd_adr_a), .rd_adr_b_o(rd_adr_b),
        .rd_bank_o(rd_bank), .twiddle_adr_o(twiddle_adr), .twiddle_conj_o(twiddle_conj),
        .wr_en_o(wr_en), .wr_adr_a_o(wr_adr_a), .wr_adr_b_o(wr_adr_b),
        .wr_bank_o(wr_bank), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_adr_o(out_adr), .level_o(level), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset;
        @(negedge clk);
        #1;
        tests++;
        if ({busy, in_ready, wr_en, out_valid, done, level} !== 7'd0) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 0000000", {busy, in_ready, wr_en, out_valid, done, level});
        end
        tests++;
        if ({rd_adr_a, wr_adr_a, out_adr, load_adr, rd_bank, wr_bank, twiddle_conj} !== 15'd0) begin
            fails++;
            $display("FAIL reset_adr got %h want 0", {rd_adr_a, wr_adr_a, out_adr, load_adr, rd_bank, wr_bank, twiddle_conj});
        end
    endtask

    task automatic test_load(input bit gap, input bit inv);
        @(negedge clk);
        start = 1'b1;
        inverse = inv;
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL start_idle busy got %b want 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        inverse = ~inv;
        for (int k = 0; k < 8; k++) begin
            if (gap) for (int g = 0; g <= k % 2; g++) begin
                in_valid = 1'b0;
                #1;
                tests++;
                if ({in_ready, load_we} !== 2'b10) begin
                    fails++;
                    $display("FAIL load_gap k=%0d got %b want 10", k, {in_ready, load_we});
                end
                @(negedge clk);
            end
            in_valid = 1'b1;
            #1;
            tests++;
            if ({load_we, load_adr} !== {1'b1, 3'(la_tab[k])}) begin
                fails++;
                $display("FAIL load_adr k=%0d got %b want %b", k, {load_we, load_adr}, {1'b1, 3'(la_tab[k])});
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        tests++;
        if ({in_ready, busy} !== 2'b01) begin
            fails++;
            $display("FAIL load_end in_ready,busy got %b want 01", {in_ready, busy});
        end
    endtask

    task automatic test_compute(input bit inv);
        int l, c;
        logic [8:0] erd;
        logic [6:0] ewr;
        for (int g = 0; g < 21; g++) begin
            if (g > 0) begin
                @(negedge clk);
                #1;
            end
            l = g / 7;
            c = g % 7;
            erd = 9'd0;
            ewr = 7'd0;
            if (c < 4) erd = {3'(ra_tab[l][c]), 3'(rb_tab[l][c]), 2'(tw_tab[l][c]), inv};
            if (c >= 3) ewr = {1'b1, 3'(ra_tab[l][c-3]), 3'(rb_tab[l][c-3])};
            tests++;
            if ({rd_adr_a, rd_adr_b, twiddle_adr, twiddle_conj} !== erd) begin
                fails++;
                $display("FAIL rd_seq cyc=%0d got %b want %b", g, {rd_adr_a, rd_adr_b, twiddle_adr, twiddle_conj}, erd);
            end
            tests++;
            if ({wr_en, wr_adr_a, wr_adr_b} !== ewr) begin
                fails++;
                $display("FAIL wr_seq cyc=%0d got %b want %b", g, {wr_en, wr_adr_a, wr_adr_b}, ewr);
            end
            tests++;
            if ({busy, level, rd_bank, wr_bank} !== {1'b1, 2'(l), l[0], ~l[0]}) begin
                fails++;
                $display("FAIL bank_level cyc=%0d got %b want %b", g, {busy, level, rd_bank, wr_bank}, {1'b1, 2'(l), l[0], ~l[0]});
            end
        end
        @(negedge clk);
        #1;
        tests++;
        if ({level, rd_bank, wr_en, wr_bank, out_valid, out_adr} !== 9'b11_1_0_0_0_000) begin
            fails++;
            $display("FAIL unload_entry got %b want 111000000", {level, rd_bank, wr_en, wr_bank, out_valid, out_adr});
        end
    endtask

    task automatic test_unload(input bit bp);
        int dones = 0;
        for (int s = 0; s < 8; s++) begin
            out_ready = 1'b1;
            tests++;
            if ({out_valid, done, out_adr} !== {2'b00, 3'(s)}) begin
                fails++;
                $display("FAIL unload_lat s=%0d got %b want %b", s, {out_valid, done, out_adr}, {2'b00, 3'(s)});
            end
            if (bp && s == 3) repeat (5) begin
                @(negedge clk);
                out_ready = 1'b0;
                #1;
                tests++;
                if ({out_valid, done, out_adr} !== 5'b10_011) begin
                    fails++;
                    $display("FAIL backpressure got %b want 10011", {out_valid, done, out_adr});
                end
            end
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            tests++;
            if ({out_valid, done, out_adr} !== {1'b1, s == 7, 3'(s)}) begin
                fails++;
                $display("FAIL unload_hs s=%0d got %b want %b", s, {out_valid, done, out_adr}, {1'b1, s == 7, 3'(s)});
            end
            if (done) dones++;
            @(negedge clk);
            #1;
        end
        tests++;
        if (busy !== 1'b0 || level !== 2'd0 || done !== 1'b0 || dones != 1) begin
            fails++;
            $display("FAIL unload_end busy=%b level=%0d dones=%0d want busy=0 level=0 dones=1", busy, level, dones);
        end
    endtask

    task automatic test_back_to_back;
        test_load(1'b0, 1'b0);
        test_compute(1'b0);
        test_unload(1'b0);
    endtask

    task automatic test_reset_mid;
        test_load(1'b0, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        tests++;
        if ({busy, wr_en} !== 2'b11) begin
            fails++;
            $display("FAIL pre_reset busy,wr_en got %b want 11", {busy, wr_en});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if ({busy, in_ready, wr_en, out_valid, done, level, twiddle_conj, wr_bank} !== 9'd0) begin
            fails++;
            $display("FAIL reset_mid got %b want 000000000", {busy, in_ready, wr_en, out_valid, done, level, twiddle_conj, wr_bank});
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        inverse = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset;
        test_load(1'b1, 1'b1);
        test_compute(1'b1);
        test_unload(1'b1);
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
- Parametrised, single-clock control sequencer for an in-place radix-2 DIT FFT of N = 2^M points, with ping-pong RAM banks.
- Runs three phases: a ready/valid load phase, a pipelined butterfly compute phase with inverse-FFT support, and a ready/valid unload phase.
- Drives only addresses, enables and handshakes. External dual-port RAM banks, the twiddle ROM and the butterfly unit form the datapath.
- FFT size, RAM read latency and butterfly latency are all parametrised.

Parameters:
- M, 9, log2 of FFT length N; legal range 2..12.
- RD_LAT, 1, RAM read latency in cycles; legal range 1..3.
- BFLY_LAT, 2, butterfly pipeline latency in cycles; legal range 0..4.
- PIPE (derived), RD_LAT+BFLY_LAT, delay from read address to write of the result.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a transform; sampled only in IDLE.
- inverse  in  1  select inverse FFT; latched on start.
- in_valid  in  1  input sample present.
- in_ready  out  1  load handshake ready.
- load_we  out  1  bank-0 write strobe (in_valid & in_ready).
- load_adr  out  M  bit-reversed load address.
- rd_adr_a  out  M  butterfly A read address.
- rd_adr_b  out  M  butterfly B read address.
- rd_bank  out  1  bank selected for reads.
- twiddle_adr  out  M-1  twiddle ROM address.
- twiddle_conj  out  1  conjugate twiddle (inverse mode).
- wr_en  out  1  butterfly result write enable.
- wr_adr_a  out  M  butterfly A write address.
- wr_adr_b  out  M  butterfly B write address.
- wr_bank  out  1  bank selected for writes.
- out_valid  out  1  unload sample valid.
- out_ready  in  1  downstream ready.
- out_adr  out  M  unload read address (natural order).
- level  out  clog2(M+1)  current stage.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the final unload handshake.

Behaviour:
- Reset: all outputs 0, FSM enters IDLE, counters 0. Reset mid-operation aborts immediately; partially written RAM contents are don't-care.
- States: IDLE, LOAD, COMPUTE, DRAIN, UNLOAD.
- IDLE: start=1 latches inverse and moves to LOAD. start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - On each in_valid handshake, cnt++ and load_adr = bitrev(cnt).
  - After the N-th handshake, in_ready drops the next cycle and the FSM moves to COMPUTE with level=0, idx=0.
  - Gaps in in_valid stall the load phase without error.
- COMPUTE:
  - One butterfly issued per cycle, idx 0..N/2-1.
  - span = 2^level, pos = idx & (span-1), grp = idx >> level.
  - rd_adr_a = (grp << (level+1)) | pos; rd_adr_b = rd_adr_a + span.
  - twiddle_adr = pos << (M-1-level); twiddle_conj = latched inverse.
  - rd_bank = level[0]; wr_bank = ~level[0].
  - wr_en, wr_adr_a and wr_adr_b equal rd-valid, rd_adr_a and rd_adr_b delayed exactly PIPE cycles through a shift pipeline.
  - After idx=N/2-1, go to DRAIN.
- DRAIN:
  - Lasts exactly PIPE cycles with no reads issued; pipelined writes complete during this state.
  - Then level++. If level==M, go to UNLOAD; otherwise return to COMPUTE with idx=0.
  - Cycles in COMPUTE+DRAIN = M*(N/2+PIPE).
- UNLOAD:
  - Reads bank M[0] at out_adr = 0..N-1 in natural order.
  - out_valid rises RD_LAT cycles after out_adr is presented and holds until out_valid & out_ready.
  - On that handshake: out_adr++, and out_valid falls for RD_LAT cycles.
  - out_ready low holds out_valid and out_adr stable.
  - On the N-th handshake: done pulses, and the FSM returns to IDLE the next cycle.
- level holds M during UNLOAD and returns to 0 in IDLE.
- No scaling is applied by this block; the 1/N scaling for the inverse transform is the datapath's responsibility.

Test Plan:
- Reset check: assert reset for 3 cycles during COMPUTE -> next cycle FSM is IDLE; busy, in_ready, wr_en, out_valid and done are all 0; level=0.
- Load with gaps (M=3): start, then 8 in_valid handshakes with idle cycles between them -> load_adr sequence 0,4,2,6,1,5,3,7; in_ready=0 after the 8th handshake.
- Address sequence (M=3):
  - level 0 -> pairs (0,1),(2,3),(4,5),(6,7), twiddle 0,0,0,0.
  - level 1 -> (0,2),(1,3),(4,6),(5,7), twiddle 0,2,0,2.
  - level 2 -> (0,4),(1,5),(2,6),(3,7), twiddle 0,1,2,3.
- Pipeline timing (M=3, RD_LAT=1, BFLY_LAT=2) -> wr_en equals rd activity delayed 3 cycles; wr_bank toggles per level; COMPUTE+DRAIN spans 21 cycles; reads never overlap pending writes.
- Inverse mode: start with inverse=1 -> twiddle_conj=1 on every COMPUTE cycle. Next run with inverse=0 -> twiddle_conj=0 throughout.
- Unload backpressure (M=3): hold out_ready=0 for 5 cycles at out_adr=3 -> out_valid and out_adr stay stable; out_adr reaches 0..7 in order; done pulses once; a second start runs correctly.
